id_pipe: RTL

Next-generation MIPS decode stage with an integrated ID/EX pipeline register. Each cycle it decodes the instruction from IF/ID and reads operands through the regfile ports. It resolves read-after-write hazards by forwarding from EX and MEM, and raises a stall request on a load-use hazard. Results are registered towards EX under stall, flush and bubble control.

---
 rtl/id_pipe.sv | 303 ++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/id_pipe.sv
// id_pipe: MIPS decode stage with EX/MEM operand forwarding, load-use hazard
// detection and an integrated ID/EX pipeline register.
module id_pipe #(
  parameter int unsigned DW     = 32,
  parameter int unsigned RAW    = 5,
  parameter bit          FWD_EN = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [31:0]     pc_i,
  input  logic [31:0]     inst_i,
  input  logic            inst_valid_i,
  input  logic [DW-1:0]   reg1_data_i,
  input  logic [DW-1:0]   reg2_data_i,
  input  logic            ex_wreg_i,
  input  logic [RAW-1:0]  ex_wd_i,
  input  logic [DW-1:0]   ex_wdata_i,
  input  logic            ex_is_load_i,
  input  logic            mem_wreg_i,
  input  logic [RAW-1:0]  mem_wd_i,
  input  logic [DW-1:0]   mem_wdata_i,
  input  logic            stall_i,
  input  logic            flush_i,
  output logic            reg1_read_o,
  output logic            reg2_read_o,
  output logic [RAW-1:0]  reg1_addr_o,
  output logic [RAW-1:0]  reg2_addr_o,
  output logic            stallreq_o,
  output logic [7:0]      aluop_o,
  output logic [2:0]      alusel_o,
  output logic [DW-1:0]   reg1_o,
  output logic [DW-1:0]   reg2_o,
  output logic [RAW-1:0]  wd_o,
  output logic            wreg_o,
  output logic [31:0]     pc_o,
  output logic            valid_o,
  output logic            inst_invalid_o
);

  localparam logic [5:0] OP_SPECIAL = 6'b000000;
  localparam logic [5:0] OP_ANDI    = 6'b001100;
  localparam logic [5:0] OP_ORI     = 6'b001101;
  localparam logic [5:0] OP_XORI    = 6'b001110;
  localparam logic [5:0] OP_LUI     = 6'b001111;

  localparam logic [5:0] FN_SLL = 6'b000000;
  localparam logic [5:0] FN_SRL = 6'b000010;
  localparam logic [5:0] FN_SRA = 6'b000011;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_XOR = 6'b100110;
  localparam logic [5:0] FN_NOR = 6'b100111;

  localparam logic [7:0] ALU_NOP = 8'h00;
  localparam logic [7:0] ALU_AND = 8'h24;
  localparam logic [7:0] ALU_OR  = 8'h25;
  localparam logic [7:0] ALU_XOR = 8'h26;
  localparam logic [7:0] ALU_NOR = 8'h27;
  localparam logic [7:0] ALU_SLL = 8'h7c;
  localparam logic [7:0] ALU_SRL = 8'h02;
  localparam logic [7:0] ALU_SRA = 8'h03;

  localparam logic [2:0] SEL_NOP   = 3'b000;
  localparam logic [2:0] SEL_LOGIC = 3'b001;
  localparam logic [2:0] SEL_SHIFT = 3'b010;

  logic [5:0]     op_s;
  logic [5:0]     funct_s;
  logic [RAW-1:0] rs_s;
  logic [RAW-1:0] rt_s;
  logic [RAW-1:0] rd_s;
  logic [DW-1:0]  imm_zext_s;
  logic [DW-1:0]  imm_lui_s;
  logic [DW-1:0]  imm_sa_s;

  logic [7:0]     dec_aluop_s;
  logic [2:0]     dec_alusel_s;
  logic           rd1_en_s;
  logic           rd2_en_s;
  logic [DW-1:0]  imm1_s;
  logic [DW-1:0]  imm2_s;
  logic [RAW-1:0] dec_wd_s;
  logic           dec_wreg_s;
  logic           dec_invalid_s;

  logic           ex_hit1_s;
  logic           ex_hit2_s;
  logic           mem_hit1_s;
  logic           mem_hit2_s;
  logic           haz1_s;
  logic           haz2_s;
  logic           stallreq_s;
  logic [DW-1:0]  opnd1_s;
  logic [DW-1:0]  opnd2_s;

  logic [7:0]     nxt_aluop_s;
  logic [2:0]     nxt_alusel_s;
  logic [DW-1:0]  nxt_reg1_s;
  logic [DW-1:0]  nxt_reg2_s;
  logic [RAW-1:0] nxt_wd_s;
  logic           nxt_wreg_s;
  logic [31:0]    nxt_pc_s;
  logic           nxt_valid_s;
  logic           nxt_invalid_s;

  logic [7:0]     aluop_r;
  logic [2:0]     alusel_r;
  logic [DW-1:0]  reg1_r;
  logic [DW-1:0]  reg2_r;
  logic [RAW-1:0] wd_r;
  logic           wreg_r;
  logic [31:0]    pc_r;
  logic           valid_r;
  logic           invalid_r;

  assign op_s       = inst_i[31:26];
  assign funct_s    = inst_i[5:0];
  assign rs_s       = RAW'(inst_i[25:21]);
  assign rt_s       = RAW'(inst_i[20:16]);
  assign rd_s       = RAW'(inst_i[15:11]);
  assign imm_zext_s = DW'(inst_i[15:0]);
  assign imm_lui_s  = DW'({inst_i[15:0], 16'h0000});
  assign imm_sa_s   = DW'(inst_i[10:6]);

  // Ungated operand priority: disabled -> immediate, r0 -> 0, then EX, MEM, regfile.
  function automatic logic [DW-1:0] pick_operand(
    input logic           en,
    input logic [RAW-1:0] addr,
    input logic [DW-1:0]  imm,
    input logic [DW-1:0]  rf_data,
    input logic           ex_hit,
    input logic [DW-1:0]  ex_data,
    input logic           mem_hit,
    input logic [DW-1:0]  mem_data
  );
    logic [DW-1:0] val;
    if (!en) val = imm;
    else if (addr == '0) val = '0;
    else if (FWD_EN && ex_hit) val = ex_data;
    else if (FWD_EN && mem_hit) val = mem_data;
    else val = rf_data;
    return val;
  endfunction

  // Instruction decode: operation, operand usage, immediates and destination.
  always_comb begin
    dec_aluop_s   = ALU_NOP;
    dec_alusel_s  = SEL_NOP;
    rd1_en_s      = 1'b0;
    rd2_en_s      = 1'b0;
    imm1_s        = '0;
    imm2_s        = '0;
    dec_wd_s      = '0;
    dec_wreg_s    = 1'b0;
    dec_invalid_s = 1'b0;
    case (op_s)
      OP_ORI, OP_ANDI, OP_XORI: begin
        dec_alusel_s = SEL_LOGIC;
        rd1_en_s     = 1'b1;
        imm2_s       = imm_zext_s;
        dec_wd_s     = rt_s;
        dec_wreg_s   = 1'b1;
        case (op_s)
          OP_ANDI: dec_aluop_s = ALU_AND;
          OP_XORI: dec_aluop_s = ALU_XOR;
          default: dec_aluop_s = ALU_OR;
        endcase
      end
      OP_LUI: begin
        dec_aluop_s  = ALU_OR;
        dec_alusel_s = SEL_LOGIC;
        imm1_s       = imm_lui_s;
        dec_wd_s     = rt_s;
        dec_wreg_s   = 1'b1;
      end
      OP_SPECIAL: begin
        case (funct_s)
          FN_OR, FN_AND, FN_XOR, FN_NOR: begin
            dec_alusel_s = SEL_LOGIC;
            rd1_en_s     = 1'b1;
            rd2_en_s     = 1'b1;
            dec_wd_s     = rd_s;
            dec_wreg_s   = 1'b1;
            case (funct_s)
              FN_AND:  dec_aluop_s = ALU_AND;
              FN_XOR:  dec_aluop_s = ALU_XOR;
              FN_NOR:  dec_aluop_s = ALU_NOR;
              default: dec_aluop_s = ALU_OR;
            endcase
          end
          FN_SLL, FN_SRL, FN_SRA: begin
            // Shifts by sa only: a nonzero rs field is not a supported encoding.
            if (inst_i[25:21] == 5'd0) begin
              dec_alusel_s = SEL_SHIFT;
              rd2_en_s     = 1'b1;
              imm1_s       = imm_sa_s;
              dec_wd_s     = rd_s;
              dec_wreg_s   = 1'b1;
              case (funct_s)
                FN_SRL:  dec_aluop_s = ALU_SRL;
                FN_SRA:  dec_aluop_s = ALU_SRA;
                default: dec_aluop_s = ALU_SLL;
              endcase
            end else begin
              dec_invalid_s = 1'b1;
            end
          end
          default: dec_invalid_s = 1'b1;
        endcase
      end
      default: dec_invalid_s = 1'b1;
    endcase
  end

  assign ex_hit1_s  = ex_wreg_i && (ex_wd_i == rs_s);
  assign ex_hit2_s  = ex_wreg_i && (ex_wd_i == rt_s);
  assign mem_hit1_s = mem_wreg_i && (mem_wd_i == rs_s);
  assign mem_hit2_s = mem_wreg_i && (mem_wd_i == rt_s);

  // Hazard detection: load-use always; without forwarding any pending write to a live source.
  always_comb begin
    haz1_s = rd1_en_s && ((ex_hit1_s && ex_is_load_i) ||
             (!FWD_EN && (rs_s != '0) && (ex_hit1_s || mem_hit1_s)));
    haz2_s = rd2_en_s && ((ex_hit2_s && ex_is_load_i) ||
             (!FWD_EN && (rt_s != '0) && (ex_hit2_s || mem_hit2_s)));
    if (inst_valid_i && !flush_i) begin
      stallreq_s = haz1_s || haz2_s;
    end else begin
      stallreq_s = 1'b0;
    end
  end

  assign opnd1_s = pick_operand(rd1_en_s, rs_s, imm1_s, reg1_data_i,
                                ex_hit1_s, ex_wdata_i, mem_hit1_s, mem_wdata_i);
  assign opnd2_s = pick_operand(rd2_en_s, rt_s, imm2_s, reg2_data_i,
                                ex_hit2_s, ex_wdata_i, mem_hit2_s, mem_wdata_i);

  // Next ID/EX contents: a bubble on flush, hazard or empty slot, else the decode.
  always_comb begin
    if (flush_i || stallreq_s || !inst_valid_i) begin
      nxt_aluop_s   = ALU_NOP;
      nxt_alusel_s  = SEL_NOP;
      nxt_reg1_s    = '0;
      nxt_reg2_s    = '0;
      nxt_wd_s      = '0;
      nxt_wreg_s    = 1'b0;
      nxt_pc_s      = 32'h0000_0000;
      nxt_valid_s   = 1'b0;
      nxt_invalid_s = 1'b0;
    end else begin
      nxt_aluop_s   = dec_aluop_s;
      nxt_alusel_s  = dec_alusel_s;
      nxt_reg1_s    = opnd1_s;
      nxt_reg2_s    = opnd2_s;
      nxt_wd_s      = dec_wd_s;
      nxt_wreg_s    = dec_wreg_s;
      nxt_pc_s      = pc_i;
      nxt_valid_s   = 1'b1;
      nxt_invalid_s = dec_invalid_s;
    end
  end

  // ID/EX register: flush overrides the downstream stall, which otherwise holds.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      aluop_r   <= ALU_NOP;
      alusel_r  <= SEL_NOP;
      reg1_r    <= '0;
      reg2_r    <= '0;
      wd_r      <= '0;
      wreg_r    <= 1'b0;
      pc_r      <= 32'h0000_0000;
      valid_r   <= 1'b0;
      invalid_r <= 1'b0;
    end else if (flush_i || !stall_i) begin
      aluop_r   <= nxt_aluop_s;
      alusel_r  <= nxt_alusel_s;
      reg1_r    <= nxt_reg1_s;
      reg2_r    <= nxt_reg2_s;
      wd_r      <= nxt_wd_s;
      wreg_r    <= nxt_wreg_s;
      pc_r      <= nxt_pc_s;
      valid_r   <= nxt_valid_s;
      invalid_r <= nxt_invalid_s;
    end
  end

  assign reg1_read_o    = rd1_en_s;
  assign reg2_read_o    = rd2_en_s;
  assign reg1_addr_o    = rs_s;
  assign reg2_addr_o    = rt_s;
  assign stallreq_o     = stallreq_s;
  assign aluop_o        = aluop_r;
  assign alusel_o       = alusel_r;
  assign reg1_o         = reg1_r;
  assign reg2_o         = reg2_r;
  assign wd_o           = wd_r;
  assign wreg_o         = wreg_r;
  assign pc_o           = pc_r;
  assign valid_o        = valid_r;
  assign inst_invalid_o = invalid_r;

endmodule
